uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Serial transmit stage downstream of Top_level. Consumes the o_data_send / o_tx_start
//  byte stream from the debug unit, queues bytes in a small FIFO and shifts them out
//  as 8N1 UART frames on o_tx. The FIFO absorbs back-to-back o_tx_start pulses
//  (one per clock) while the MIPS state dump is serialised.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock in Hz
//  BAUD        9600        line rate in bit/s
//  DATA_BITS   8           payload bits per frame
//  SB_TICKS    16          stop-bit length in oversample ticks (16 = 1 stop bit)
//  FIFO_DEPTH  16          queue entries; power of 2, >= 2
//  DIVISOR = CLK_FREQ/(BAUD*16), integer truncation; defaults give 325; must be >= 1
// PORTS
//  clk            in   1          system clock, rising edge
//  rst            in   1          synchronous reset, active-high
//  i_tx_start     in   1          push strobe, one byte per cycle while high
//  i_data_send    in   DATA_BITS  byte to queue, sampled with i_tx_start
//  o_tx           out  1          serial line, idles high
//  o_tx_done      out  1          1-cycle pulse at end of each frame's stop bit
//  o_busy         out  1          1 while FIFO non-empty or a frame is on the line
//  o_fifo_full    out  1          FIFO holds FIFO_DEPTH entries
//  o_overflow     out  1          sticky: a push was dropped; cleared only by rst
// BEHAVIOUR
//  Reset (rst=1 at an edge): o_tx=1, o_tx_done=0, o_busy=0, o_fifo_full=0, o_overflow=0,
//   FIFO emptied, FSM->IDLE. Reset mid-frame aborts it; line is high the next cycle.
//  FIFO: registered, no fall-through. Push accepted if !full, or if full and a pop
//   occurs the same cycle. Rejected push sets o_overflow; data is discarded.
//   Simultaneous push+pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Baud gen: counter 0..DIVISOR-1 yields a 1-cycle tick; cleared on every pop, so
//   each bit lasts exactly 16*DIVISOR cycles.
//  FSM (o_tx registered from state/shift reg):
//   IDLE : o_tx=1; if FIFO non-empty -> pop into shift reg, tick_cnt=0, -> START.
//   START: o_tx=0 for 16 ticks -> DATA, bit_cnt=0.
//   DATA : o_tx=shift[0], LSB first; every 16 ticks shift right, bit_cnt++;
//          after DATA_BITS bits -> STOP.
//   STOP : o_tx=1 for SB_TICKS ticks; at the final tick o_tx_done=1 for that cycle.
//          If FIFO non-empty, pop and go straight to START (no idle gap), else -> IDLE.
//  Latency: push at edge N into an empty FIFO with FSM idle -> pop at edge N+1 ->
//   o_tx low from edge N+2.
//  Frame length: (1+DATA_BITS)*16*DIVISOR + SB_TICKS*DIVISOR cycles (defaults: 52000).
//  Pushes during a frame never disturb the frame in flight.
//  o_busy = (state!=IDLE) | !empty; combinational from registered state.
// STRUCTURE
//  Shared include uart_defs.vh: FSM state encodings (IDLE/START/DATA/STOP),
//   OVERSAMPLE=16, DIVISOR computation macro; uart_rx reuses it.
//  Sub-module uart_baud_gen (DIVISOR param; clk, rst, i_clear, o_tick) holds the
//   divider counter. FIFO storage, pointers and FSM stay inline.
// TESTING  (bench params: CLK_FREQ=1_600_000, BAUD=100_000 -> DIVISOR=1, 16 cycles/bit)
//  1 Reset: hold rst 3 cycles -> o_tx=1, o_busy=0, o_fifo_full=0, o_overflow=0, no o_tx_done.
//  2 Single byte 8'hA5 pushed into idle block -> o_tx low 2 edges after push; line reads
//    0,1,0,1,0,0,1,0,1,1 at 16 cycles/bit; o_tx_done pulses once after 160 cycles.
//  3 Burst 8'h01,02,03,04 on 4 consecutive cycles -> four contiguous frames, no idle gap,
//    LSB-first payloads in order, exactly 4 o_tx_done pulses, o_busy drops after the last.
//  4 Push 18 bytes back-to-back with FIFO_DEPTH=16 -> o_fifo_full asserts, o_overflow
//    sets, first 17 bytes (1 in flight + 16 queued) go out in order, the 18th never
//    appears; o_overflow stays 1 until rst.
//  5 With FIFO full, push on the cycle STOP pops -> push accepted, o_overflow stays 0.
//  6 Assert rst in the middle of the DATA phase of 8'hFF with 3 bytes queued -> o_tx=1
//    next cycle, o_busy=0, nothing is transmitted afterwards until a new push.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// oversample ratio and the baud divisor computation.
package uart_tx_fifo_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Clock cycles per oversample tick, truncated, never below 1.
  function automatic int calc_divisor(input int clk_freq, input int baud);
    int div;
    div = clk_freq / (baud * OVERSAMPLE);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: a 0..DIVISOR-1 counter that emits a one-cycle
// tick on its terminal count. i_clear restarts the count so a bit period
// begins exactly at the clear.
module uart_baud_gen #(
  parameter int DIVISOR = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] cnt_q;

  assign o_tick = (cnt_q == CW'(DIVISOR - 1));

  // Divider counter, restarted by reset or clear, wraps at DIVISOR-1.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      cnt_q <= '0;
    end else if (o_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter.
// Handshake: i_tx_start is a push strobe with no ready; a byte is taken on
// every cycle it is high unless the FIFO is full and no pop happens that
// cycle, in which case the byte is dropped and o_overflow latches.
// o_fifo_full is advisory for the producer. o_state exposes the FSM state.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int SB_TICKS   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_data_send,
  output logic                 o_tx,
  output logic                 o_tx_done,
  output logic                 o_busy,
  output logic                 o_fifo_full,
  output logic                 o_overflow,
  output logic [1:0]           o_state
);

  localparam int DIVISOR  = calc_divisor(CLK_FREQ, BAUD);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int TICK_MAX = (SB_TICKS > OVERSAMPLE) ? SB_TICKS : OVERSAMPLE;
  localparam int TW       = $clog2(TICK_MAX);
  localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 full, empty, pop, push_ok;

  // Transmitter state
  tx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_bit, tx_done, tick;
  logic                 overflow_q;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO still takes a byte when the FSM pops in the same cycle.
  assign push_ok = i_tx_start && (!full || pop);

  uart_baud_gen #(.DIVISOR(DIVISOR)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .i_clear (pop),
    .o_tick  (tick)
  );

  // FIFO write port; storage is not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= i_data_send;
    end
  end

  // FIFO pointers and occupancy; push+pop together keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky record of any dropped push.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (i_tx_start && !push_ok) begin
      overflow_q <= 1'b1;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Next-state logic: frame sequencing, pops and the end-of-frame pulse.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    tx_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = mem[rd_ptr_q];
          tick_cnt_d = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == TW'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tick_cnt_q == TW'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
              state_d = ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tick_cnt_q == TW'(SB_TICKS - 1)) begin
            tx_done    = 1'b1;
            tick_cnt_d = '0;
            // Chain straight into the next frame when bytes are waiting.
            if (!empty) begin
              pop     = 1'b1;
              shift_d = mem[rd_ptr_q];
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level implied by the current state.
  always_comb begin
    tx_bit = 1'b1;
    case (state_q)
      ST_START: tx_bit = 1'b0;
      ST_DATA:  tx_bit = shift_q[0];
      default:  tx_bit = 1'b1;
    endcase
  end

  // Registered serial output so the line is glitch-free; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= 1'b1;
    end else begin
      tx_q <= tx_bit;
    end
  end

  assign o_tx        = tx_q;
  assign o_tx_done   = tx_done;
  assign o_busy      = (state_q != ST_IDLE) || !empty;
  assign o_fifo_full = full;
  assign o_overflow  = overflow_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DIVISOR=1 (16 cycles per bit, 160 per frame).
// A frame-level model (byte queue plus position within the current frame)
// predicts every output each cycle; directed tests pin the model with
// hand-computed literals and a bench-side serial receiver.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int FRAME = 160;

  // Clock and reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] data_send = 8'h00;
  logic       tx, tx_done, busy, fifo_full, overflow;
  logic [1:0] dut_state;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (100_000),
    .DATA_BITS  (8),
    .SB_TICKS   (16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tx_start  (tx_start),
    .i_data_send (data_send),
    .o_tx        (tx),
    .o_tx_done   (tx_done),
    .o_busy      (busy),
    .o_fifo_full (fifo_full),
    .o_overflow  (overflow),
    .o_state     (dut_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: bytes waiting, byte on the line, cycle within frame.
  logic [7:0] mq[$];
  logic [7:0] m_cur;
  bit         m_active, m_ovf, m_valid, m_pop, m_end, m_acc;
  logic       m_line, m_nl;
  int         m_t, m_nq;

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j <= 16) return 1'b0;
    if (j <= 144) return b[(j - 17) / 16];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_active = 0; m_t = 0; m_line = 1'b1; m_ovf = 0; m_valid = 1;
    end else if (m_valid) begin
      m_nl  = m_active ? frame_bit(m_cur, m_t) : 1'b1;
      m_nq  = mq.size();
      m_end = m_active && (m_t == FRAME);
      m_pop = (m_nq > 0) && (!m_active || m_end);
      m_acc = tx_start && ((m_nq < DEPTH) || m_pop);
      if (tx_start && !m_acc) m_ovf = 1;
      if (m_pop) begin
        m_cur = mq.pop_front(); m_active = 1; m_t = 1;
      end else if (m_end) begin
        m_active = 0;
      end else if (m_active) begin
        m_t++;
      end
      if (m_acc) mq.push_back(data_send);
      m_line = m_nl;
    end
  end

  // Compare process: every output against the model, every cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_tx", {31'd0, tx}, {31'd0, m_line});
      chk("cmp_done", {31'd0, tx_done}, {31'd0, m_active && m_t == FRAME});
      chk("cmp_busy", {31'd0, busy}, {31'd0, m_active || mq.size() > 0});
      chk("cmp_full", {31'd0, fifo_full}, {31'd0, mq.size() == DEPTH});
      chk("cmp_ovf", {31'd0, overflow}, {31'd0, m_ovf});
      chk("cmp_idle_state", {31'd0, dut_state == ST_IDLE}, {31'd0, !m_active});
    end
  end

  // Bench-side receiver and done-pulse monitor (mid-bit sampling).
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_sh;
  bit         rx_busy = 0;
  logic       rx_prev = 1'b1;
  int         rx_cnt, done_cnt = 0;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (rst) begin
      rx_busy = 0; rx_prev = 1'b1;
    end else begin
      if (rx_busy) begin
        rx_cnt++;
        if (rx_cnt % 16 == 8 && rx_cnt >= 24 && rx_cnt <= 136)
          rx_sh = {tx, rx_sh[7:1]};
        if (rx_cnt == 152) begin
          rx_busy = 0;
          rx_q.push_back(rx_sh);
        end
      end else if (rx_prev === 1'b1 && tx === 1'b0) begin
        rx_busy = 1; rx_cnt = 0;
      end
      rx_prev = tx;
    end
  end

  // Driver tasks
  logic [7:0] seq[32];
  int         tk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk); tk++;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
    rst = 1'b0;
  endtask

  // One byte per cycle; tk counts edges from the first push edge.
  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) begin
      tx_start = 1'b1; data_send = seq[i];
      @(posedge clk); @(negedge clk);
      if (i == 0) tk = 0; else tk++;
    end
    tx_start = 1'b0; data_send = 8'h00;
  endtask

  task automatic wait_idle(input int limit, output int steps);
    steps = 0;
    while (busy !== 1'b0 && steps < limit) begin
      step(1); steps++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_rx(input string name);
    int n;
    chk({name, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
  endtask

  logic [9:0] a5_line;
  int         st, found, d0, lows;

  initial begin
    @(negedge clk);

    // 1: reset held 3 cycles
    do_reset(3);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_done_cnt", done_cnt, 32'd0);

    // 2: single byte 8'hA5; line is start,1,0,1,0,0,1,0,1,stop (index 0 first)
    rx_q.delete(); d0 = done_cnt;
    a5_line = 10'b11_0100_1010;
    seq[0] = 8'hA5;
    push_seq(1);
    chk("a5_k0_tx", {31'd0, tx}, 32'd1);
    step(1); chk("a5_k1_tx", {31'd0, tx}, 32'd1);
    step(1); chk("a5_k2_tx", {31'd0, tx}, 32'd0);
    step(8);
    for (int b = 0; b < 10; b++) begin
      if (b > 0) step(16);
      chk("a5_line_bit", {31'd0, tx}, {31'd0, a5_line[b]});
    end
    found = 0;
    while (found == 0 && tk < 200) begin
      step(1);
      if (tx_done === 1'b1) found = tk;
    end
    chk("a5_done_cycle", found, 32'd160);
    step(1);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);
    chk("a5_done_pulses", done_cnt - d0, 32'd1);
    exp_q = '{8'hA5};
    check_rx("a5_rx");

    // 3: burst of four on consecutive cycles, contiguous frames
    rx_q.delete(); d0 = done_cnt;
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h04;
    push_seq(4);
    wait_idle(5 * FRAME, st);
    chk("burst_busy_drop", tk, 32'd641);
    chk("burst_done_pulses", done_cnt - d0, 32'd4);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_rx("burst_rx");

    // 4: 18 back-to-back pushes into depth 16: 18th dropped
    rx_q.delete(); d0 = done_cnt; exp_q.delete();
    for (int i = 0; i < 18; i++) seq[i] = 8'h10 + 8'(i);
    push_seq(18);
    chk("ovf_full", {31'd0, fifo_full}, 32'd1);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    wait_idle(19 * FRAME, st);
    for (int i = 0; i < 17; i++) exp_q.push_back(8'h10 + 8'(i));
    check_rx("ovf_rx");
    chk("ovf_done_pulses", done_cnt - d0, 32'd17);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    do_reset(1);
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // 5: push into a full FIFO on the cycle STOP pops
    rx_q.delete(); exp_q.delete();
    for (int i = 0; i < 17; i++) seq[i] = 8'h30 + 8'(i);
    push_seq(17);
    chk("pp_full", {31'd0, fifo_full}, 32'd1);
    chk("pp_ovf_before", {31'd0, overflow}, 32'd0);
    step(160 - tk);
    chk("pp_done_at_pop", {31'd0, tx_done}, 32'd1);
    tx_start = 1'b1; data_send = 8'h41;
    step(1);
    tx_start = 1'b0; data_send = 8'h00;
    chk("pp_ovf_after", {31'd0, overflow}, 32'd0);
    chk("pp_still_full", {31'd0, fifo_full}, 32'd1);
    wait_idle(19 * FRAME, st);
    for (int i = 0; i < 18; i++) exp_q.push_back(8'h30 + 8'(i));
    check_rx("pp_rx");
    chk("pp_ovf_end", {31'd0, overflow}, 32'd0);

    // 6: reset in the DATA phase of 8'hFF with three bytes queued
    do_reset(1);
    rx_q.delete(); d0 = done_cnt;
    seq[0] = 8'hFF; seq[1] = 8'h11; seq[2] = 8'h22; seq[3] = 8'h33;
    push_seq(4);
    step(59 - tk);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mrst_tx", {31'd0, tx}, 32'd1);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_full", {31'd0, fifo_full}, 32'd0);
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (tx !== 1'b1) lows++;
    end
    chk("mrst_quiet_line", lows, 32'd0);
    chk("mrst_no_rx", rx_q.size(), 32'd0);
    chk("mrst_no_done", done_cnt - d0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog in case a wait ever escapes its bound.
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
